// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    // Scancode prefixes folded into the following key event
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Frame receiver states (fixed encoding kept for legacy netlists)
    typedef logic [1:0] ps2_state_t;
    localparam ps2_state_t IDLE   = 2'd0;
    localparam ps2_state_t DATA   = 2'd1;
    localparam ps2_state_t PARITY = 2'd2;
    localparam ps2_state_t STOP   = 2'd3;

    // One decoded key event; 'rel' is the break flag ('release' is a keyword)
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_event_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, FILTER_LEN-sample hysteresis filter and
// falling-edge strobe for the raw PS/2 clock line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic n_reset,
    input  logic pin,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] hist;
    logic                  filt;
    logic                  filt_d;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) sync <= '1;
        else          sync <= {sync[0], pin};
    end

    // Keep the last FILTER_LEN synchronised samples
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) hist <= '1;
        else          hist <= {hist[FILTER_LEN-2:0], sync[1]};
    end

    // Filtered level only moves on a unanimous window, otherwise holds
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            if (hist == '0)      filt <= 1'b0;
            else if (hist == '1) filt <= 1'b1;
            filt_d <= filt;
        end
    end

    assign fall = filt_d & ~filt;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard front end: deserialises device-to-host frames and folds
// E0/F0 prefixes into single key events.
// Optional macro PS2_RX_FIFO_EN adds a 4-entry event FIFO with valid/ready.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int CLK_MHZ    = 25,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       rx_err
);

    localparam logic [12:0] TO_LIM = 13'(CLK_MHZ * TIMEOUT_US);

    logic        clk_fall;
    logic [1:0]  data_sync;
    logic        data_s;
    ps2_state_t  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [12:0] tcount;
    logic        ext_flag;
    logic        rel_flag;

    logic        frame_done;
    logic        frame_ok;
    logic        frame_bad;
    logic        timeout;
    logic        ev_push;
    logic        push_drop;
    key_event_t  ev_new;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .n_reset(n_reset),
        .pin    (ps2clk),
        .fall   (clk_fall)
    );

    // Data pin only needs synchronising; it is stable around clock edges
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) data_sync <= '1;
        else          data_sync <= {data_sync[0], ps2data};
    end

    assign data_s = data_sync[1];

    // Frame completion, checking and event formation
    always_comb begin
        frame_done = clk_fall && (state == STOP);
        frame_ok   = frame_done && (^{shreg, par_bit}) && data_s;
        frame_bad  = frame_done && !((^{shreg, par_bit}) && data_s);
        // A falling edge in the same cycle beats the timeout
        timeout    = !clk_fall && (state != IDLE) && (tcount >= TO_LIM);
        ev_push    = frame_ok && (shreg != PS2_EXT) && (shreg != PS2_BREAK);
        ev_new     = '{code: shreg, ext: ext_flag, rel: rel_flag};
    end

    // Frame FSM and inter-edge timeout counter
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tcount  <= '0;
        end else if (timeout) begin
            state  <= IDLE;
            tcount <= '0;
        end else if (clk_fall) begin
            tcount <= '0;
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shreg   <= {data_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= PARITY;
                end
                PARITY: begin
                    par_bit <= data_s;
                    state   <= STOP;
                end
                default: state <= IDLE;
            endcase
        end else if (state != IDLE && tcount != '1) begin
            tcount <= tcount + 13'd1;
        end
    end

    // Prefix flags: set by E0/F0, cleared by any event or error
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
        end else if (timeout || frame_bad) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
        end else if (frame_ok) begin
            if (shreg == PS2_EXT) begin
                ext_flag <= 1'b1;
            end else if (shreg == PS2_BREAK) begin
                rel_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end
        end
    end

    // Error pulse for parity/stop failures, timeouts and FIFO overflow
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) rx_err <= 1'b0;
        else          rx_err <= timeout || frame_bad || push_drop;
    end

`ifdef PS2_RX_FIFO_EN
    key_event_t mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       pop;
    logic       push_ok;

    assign pop       = (count != 3'd0) && key_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push_ok   = ev_push && ((count != 3'd4) || pop);
    assign push_drop = ev_push && !push_ok;

    // Event FIFO storage and pointers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= ev_new;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Outputs present the FIFO head
    always_comb begin
        key_valid   = (count != 3'd0);
        key_code    = mem[rd_ptr].code;
        key_ext     = mem[rd_ptr].ext;
        key_release = mem[rd_ptr].rel;
    end
`else
    logic unused_ready;
    assign unused_ready = key_ready;
    assign push_drop    = 1'b0;

    // One-cycle valid pulse; event fields hold until the next event
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_valid <= ev_push;
            if (ev_push) begin
                key_code    <= ev_new.code;
                key_ext     <= ev_new.ext;
                key_release <= ev_new.rel;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx with a scancode-level reference model.
module tb_ps2_key_rx;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       ps2clk;
    logic       ps2data;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       rx_err;

    int vectors = 0;
    int miss    = 0;

    // Reference model state: pending events, expected errors, prefix flags
    logic [9:0] exp_q [$];
    int         exp_err = 0;
    bit         m_ext   = 0;
    bit         m_rel   = 0;

    // Observed behaviour
    int         seen_err = 0;
    int         ev_cnt   = 0;
    logic [7:0] last_code = '0;
    logic       last_ext  = 0;
    logic       last_rel  = 0;
    logic       prev_valid = 0;
    logic       prev_err   = 0;

    ps2_key_rx #(
        .CLK_MHZ   (25),
        .FILTER_LEN(8),
        .TIMEOUT_US(200)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .rx_err     (rx_err)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Scancode-level rules: prefixes fold, errors clear them, FIFO holds 4
    task automatic model_frame(input logic [7:0] b, input bit good);
        bit full;
        full = 0;
`ifdef PS2_RX_FIFO_EN
        full = (exp_q.size() >= 4);
`endif
        if (!good) begin
            exp_err++;
            m_ext = 0;
            m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            if (full) exp_err++;
            else      exp_q.push_back({b, m_ext, m_rel});
            m_ext = 0;
            m_rel = 0;
        end
    endtask

    // Drive the first nbits of an 11-bit frame, one bit per clock low pulse
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int half, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2data = f[i];
            settle(half);
            ps2clk = 1'b0;
            settle(half);
            ps2clk = 1'b1;
        end
        settle(half);
        ps2data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input int half);
        model_frame(b, !bad_par);
        send_bits(b, bad_par, half, 11);
        settle(20);
    endtask

    // Compare process: every accepted event against the model queue
    always @(negedge clk) begin
        if (n_reset) begin
            if (key_valid && key_ready) begin
`ifndef PS2_RX_FIFO_EN
                check("valid pulse width", prev_valid, 0);
`endif
                if (exp_q.size() == 0) begin
                    vectors++;
                    miss++;
                    $display("FAIL unexpected event: got code %02h ext %0d rel %0d, required none",
                             key_code, key_ext, key_release);
                end else begin
                    check("event {code,ext,rel}", {key_code, key_ext, key_release}, exp_q.pop_front());
                end
                last_code = key_code;
                last_ext  = key_ext;
                last_rel  = key_release;
                ev_cnt++;
            end
            if (rx_err) begin
                check("rx_err pulse width", prev_err, 0);
                seen_err++;
            end
        end
        prev_valid = key_valid;
        prev_err   = rx_err;
    end

    initial begin
        n_reset   = 1'b0;
        ps2clk    = 1'b1;
        ps2data   = 1'b1;
        key_ready = 1'b1;
        settle(5);
        check("reset key_valid", key_valid, 0);
        check("reset key_code", key_code, 0);
        check("reset key_ext", key_ext, 0);
        check("reset key_release", key_release, 0);
        check("reset rx_err", rx_err, 0);
        n_reset = 1'b1;
        settle(20);

        // Plain make code at ~12 kHz bit clock
        frame(8'h1C, 0, 1042);
        check("t1 events", ev_cnt, 1);
        check("t1 code", last_code, 8'h1C);
        check("t1 ext", last_ext, 0);
        check("t1 rel", last_rel, 0);
`ifndef PS2_RX_FIFO_EN
        settle(50);
        check("t1 code holds", key_code, 8'h1C);
`endif

        // Extended break folds into one event; next code is plain
        frame(8'hE0, 0, 60);
        frame(8'hF0, 0, 60);
        frame(8'h75, 0, 60);
        check("t2 events", ev_cnt, 2);
        check("t2 code", last_code, 8'h75);
        check("t2 ext", last_ext, 1);
        check("t2 rel", last_rel, 1);
        frame(8'h75, 0, 60);
        check("t2b events", ev_cnt, 3);
        check("t2b ext", last_ext, 0);
        check("t2b rel", last_rel, 0);

        // Parity error drops the frame and the pending E0
        frame(8'hE0, 0, 60);
        frame(8'h1C, 1, 60);
        check("t3 errors", seen_err, 1);
        check("t3 no event", ev_cnt, 3);
        frame(8'h32, 0, 60);
        check("t3 events", ev_cnt, 4);
        check("t3 code", last_code, 8'h32);
        check("t3 ext", last_ext, 0);

        // Truncated frame times out and clears the pending F0
        frame(8'hF0, 0, 60);
        send_bits(8'h5A, 0, 60, 6);
        exp_err++;
        m_ext = 0;
        m_rel = 0;
        settle(5200);
        check("t4 timeout error", seen_err, 2);
        frame(8'h5A, 0, 60);
        check("t4 events", ev_cnt, 5);
        check("t4 code", last_code, 8'h5A);
        check("t4 rel", last_rel, 0);

        // Short clock glitches and a lone data=1 edge in idle are ignored
        for (int g = 0; g < 5; g++) begin
            ps2clk = 1'b0;
            settle(3);
            ps2clk = 1'b1;
            settle(30);
        end
        ps2data = 1'b1;
        ps2clk  = 1'b0;
        settle(60);
        ps2clk  = 1'b1;
        settle(100);
        check("t5 no error", seen_err, 2);
        check("t5 no event", ev_cnt, 5);
        frame(8'hAA, 0, 60);
        check("t5 events", ev_cnt, 6);
        check("t5 code", last_code, 8'hAA);

        // Reset mid-frame discards it silently
        send_bits(8'h33, 0, 60, 4);
        n_reset = 1'b0;
        settle(3);
        n_reset = 1'b1;
        m_ext = 0;
        m_rel = 0;
        settle(20);
        check("t6 no error", seen_err, 2);
        check("t6 no event", ev_cnt, 6);
        frame(8'hE1, 0, 60);
        check("t6 events", ev_cnt, 7);
        check("t6 code", last_code, 8'hE1);

`ifdef PS2_RX_FIFO_EN
        // Fill the FIFO with the consumer stalled, overflow once, then drain
        key_ready = 1'b0;
        settle(2);
        frame(8'h15, 0, 60);
        frame(8'h1D, 0, 60);
        frame(8'h24, 0, 60);
        frame(8'h2D, 0, 60);
        check("fifo head valid", key_valid, 1);
        check("fifo head code", key_code, 8'h15);
        frame(8'h2C, 0, 60);
        check("fifo overflow error", seen_err, 3);
        check("fifo nothing popped", ev_cnt, 7);
        key_ready = 1'b1;
        settle(10);
        check("fifo drained count", ev_cnt, 11);
        check("fifo last code", last_code, 8'h2D);
        check("fifo empty", key_valid, 0);
`endif

        check("pending events", exp_q.size(), 0);
        check("error count", seen_err, exp_err);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
Name: ps2_key_rx

Overview:
- PS/2 keyboard front end, directly upstream of the UK101 core's keyboard matrix logic.
- Synchronises and filters raw ps2clk/ps2data and deserialises 11-bit device-to-host frames.
- Folds E0 (extended) and F0 (break) prefixes into a single key event: code plus flags.
- Runs in the single pixel/system clock domain (25 MHz on ULX2S).

Parameters:
- CLK_MHZ, 25, system clock frequency in MHz; scales the timeout.
- FILTER_LEN, 8, length of the glitch-filter sample window on ps2clk, in cycles (range 2..16).
- TIMEOUT_US, 200, maximum gap between falling edges inside one frame before the frame is aborted.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- ps2clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2data  in  1  raw PS/2 data pin, asynchronous.
- key_valid  out  1  key event available.
- key_ready  in  1  consumer accepts event; used only with PS2_RX_FIFO_EN, ignored otherwise.
- key_code  out  8  scancode of the event.
- key_ext  out  1  event was preceded by E0.
- key_release  out  1  event was preceded by F0.
- rx_err  out  1  one-cycle pulse on parity, stop or timeout error.

Behaviour:
- Reset (async, n_reset=0): all outputs 0; state IDLE; prefix flags cleared; synchronisers load 1; filter loads all-ones; timeout counter 0.
- Sync: both pins pass through 2 flip-flops each.
- Filter: the filtered clock goes 0 only when the last FILTER_LEN synced samples are all 0, and goes 1 only when they are all 1; otherwise it holds.
- Data sampling: data is sampled on the falling edge of the filtered clock (registered edge detect). Total latency from pin to sample is 2 + FILTER_LEN + 1 cycles.
- FSM, one transition per falling edge:
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay in IDLE (ignored, no error).
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: return to IDLE. Check odd parity (XOR of 8 data bits and parity bit = 1) and data=1.
    - Any failure: rx_err pulses 1 cycle, no event, prefix flags cleared.
- Timeout:
  - Counter is cleared on every falling edge and counts while state != IDLE.
  - At CLK_MHZ*TIMEOUT_US cycles (5000 at defaults; 13-bit counter, saturating): state -> IDLE, rx_err pulses, prefix flags cleared.
- Decode, on a good frame:
  - byte E0: set ext flag, no event.
  - byte F0: set rel flag, no event.
  - any other byte (including E1 and AA): emit an event with key_code=byte, key_ext=ext flag, key_release=rel flag, then clear both flags.
- Emit timing without FIFO:
  - key_valid is a 1-cycle pulse, one cycle after the STOP edge.
  - key_code, key_ext and key_release hold their values until the next event.
- Simultaneous events: an error and a good frame cannot share a cycle. A timeout in the cycle of a falling edge: the edge wins and the counter clears.
- Reset mid-frame: the frame is discarded; no event and no rx_err.

Optional Feature:
- Macro: PS2_RX_FIFO_EN.
- Defined:
  - A 4-entry FIFO of {code, ext, release} with valid/ready handshake.
  - key_valid = FIFO non-empty; outputs show the FIFO head.
  - Pop occurs when key_valid and key_ready are both 1.
  - Push while full: the event is dropped and rx_err pulses.
  - Push and pop in the same cycle when full: the pop frees space, so the push succeeds.
  - Reset empties the FIFO.
- Undefined: pulse behaviour as above; key_ready is unused.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT = 8'hE0 and PS2_BREAK = 8'hF0;
  - FSM state typedef {IDLE, DATA, PARITY, STOP};
  - key event struct {code[7:0], ext, release}.
- One sub-module is natural: ps2_line_filter (2-FF sync plus FILTER_LEN hysteresis filter plus fall-edge strobe), instanced once for ps2clk. ps2data uses its synchroniser only.

Test Plan:
- Send frame 0x1C (parity bit 0, 12 kHz bit clock) -> one key_valid, key_code=8'h1C, key_ext=0, key_release=0.
- Send E0,F0,0x75 -> exactly one event: key_code=8'h75, key_ext=1, key_release=1. A following 0x75 alone reports ext=0, rel=0.
- Send 0x1C with the parity bit flipped -> rx_err pulse, no key_valid. A following good 0x32 reports ext=0, rel=0.
- Stop after 5 data bits, wait 5000+ cycles -> rx_err pulse, state IDLE. A next full frame 0x5A decodes correctly.
- Inject 3-cycle low glitches on ps2clk while idle (FILTER_LEN=8) -> no state change, no rx_err.
- With PS2_RX_FIFO_EN, key_ready=0: send 0x15,0x1D,0x24,0x2D,0x2C.
  - Expected: first four are held and the 5th gives rx_err.
  - Then key_ready=1: codes 15,1D,24,2D appear in order, then key_valid=0.
